gayle_xfer_ctrl: RTL and testbench

GAYLE_XFER_CTRL -- requirements
Module: gayle_xfer_ctrl

---
 rtl/gayle_xfer_ctrl.sv | 108 ++++++++++
 tb/tb_gayle_xfer_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gayle_xfer_ctrl.sv
// Sector transfer sequencer for the Gayle IDE data port: steers the shared sector
// FIFO between the host side and the CPU side and produces the ATA status bits.
module gayle_xfer_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       cmd_start,
  input  logic       cmd_write,
  input  logic [7:0] sector_count,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic       hst_rd,
  input  logic       hst_wr,
  input  logic       abort,
  input  logic       status_rd,
  input  logic       fifo_last_in,
  input  logic       fifo_last_out,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       fifo_clr,
  output logic       fifo_host,
  output logic       bsy,
  output logic       drq,
  output logic       irq,
  output logic       hst_req,
  output logic [8:0] sectors_left
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_HOST = 3'd1;
  localparam logic [2:0] RD_CPU  = 3'd2;
  localparam logic [2:0] WR_CPU  = 3'd3;
  localparam logic [2:0] WR_HOST = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [8:0] sl_nxt;
  logic [8:0] sl_dec;
  logic       accept;
  logic       irq_set;

  assign fifo_wr   = (state == RD_HOST && hst_wr) || (state == WR_CPU && cpu_wr);
  assign fifo_rd   = (state == RD_CPU && cpu_rd) || (state == WR_HOST && hst_rd);
  assign fifo_host = (state == RD_HOST);

  // Abort overrides everything, including a command strobe in the same cycle.
  always_comb begin
    state_nxt = state;
    sl_nxt    = sectors_left;
    accept    = 1'b0;
    irq_set   = 1'b0;
    sl_dec    = (sectors_left == 9'd0) ? 9'd0 : sectors_left - 9'd1;
    if (abort) begin
      state_nxt = IDLE;
      sl_nxt    = 9'd0;
    end else begin
      case (state)
        IDLE: if (cmd_start) begin
          accept    = 1'b1;
          sl_nxt    = (sector_count == 8'd0) ? 9'd256 : {1'b0, sector_count};
          state_nxt = cmd_write ? WR_CPU : RD_HOST;
        end
        RD_HOST: if (hst_wr && fifo_last_in) begin
          state_nxt = RD_CPU;
          irq_set   = 1'b1;
        end
        RD_CPU: if (cpu_rd && fifo_last_out) begin
          sl_nxt    = sl_dec;
          state_nxt = (sl_dec == 9'd0) ? IDLE : RD_HOST;
        end
        WR_CPU: if (cpu_wr && fifo_last_in) begin
          state_nxt = WR_HOST;
        end
        WR_HOST: if (hst_rd && fifo_last_out) begin
          sl_nxt    = sl_dec;
          irq_set   = 1'b1;
          state_nxt = (sl_dec == 9'd0) ? IDLE : WR_CPU;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status bits are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sectors_left <= 9'd0;
      bsy          <= 1'b0;
      drq          <= 1'b0;
      hst_req      <= 1'b0;
      irq          <= 1'b0;
      fifo_clr     <= 1'b0;
    end else if (clk7_en) begin
      state        <= state_nxt;
      sectors_left <= sl_nxt;
      bsy          <= accept || state_nxt == RD_HOST || state_nxt == WR_HOST;
      drq          <= state_nxt == RD_CPU || state_nxt == WR_CPU;
      hst_req      <= state_nxt == RD_HOST || state_nxt == WR_HOST;
      fifo_clr     <= abort || accept;
      if (irq_set)
        irq <= 1'b1;
      else if (status_rd || accept)
        irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// Scenario bench for gayle_xfer_ctrl: expected status snapshots are queued as
// stimulus is driven and popped when the DUT is sampled one step after the edge.
module tb_gayle_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, clk7_en, cmd_start, cmd_write;
  logic [7:0] sector_count;
  logic       cpu_rd, cpu_wr, hst_rd, hst_wr, abort, status_rd;
  logic       fifo_last_in, fifo_last_out;
  logic       fifo_rd, fifo_wr, fifo_clr, fifo_host;
  logic       bsy, drq, irq, hst_req;
  logic [8:0] sectors_left;

  typedef struct {
    string      name;
    logic [4:0] flags;
    logic [8:0] sl;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [4:0] obs_flags;

  // Flag order everywhere: {bsy, drq, irq, hst_req, fifo_clr}
  assign obs_flags = {bsy, drq, irq, hst_req, fifo_clr};

  always #5 clk = ~clk;

  gayle_xfer_ctrl dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .sector_count(sector_count),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .hst_rd(hst_rd), .hst_wr(hst_wr),
    .abort(abort), .status_rd(status_rd),
    .fifo_last_in(fifo_last_in), .fifo_last_out(fifo_last_out),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_clr(fifo_clr), .fifo_host(fifo_host),
    .bsy(bsy), .drq(drq), .irq(irq), .hst_req(hst_req), .sectors_left(sectors_left)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [4:0] f, input logic [8:0] s);
    exp_t x;
    x.name  = n;
    x.flags = f;
    x.sl    = s;
    sb.push_back(x);
  endtask

  task automatic clear_inputs();
    cmd_start = 0; cmd_write = 0; sector_count = 0;
    cpu_rd = 0; cpu_wr = 0; hst_rd = 0; hst_wr = 0;
    abort = 0; status_rd = 0; fifo_last_in = 0; fifo_last_out = 0;
  endtask

  // which: 0=hst_wr 1=cpu_rd 2=cpu_wr 3=hst_rd; last marks the final word of a sector
  task automatic burst(input int which, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      hst_wr = (which == 0);
      cpu_rd = (which == 1);
      cpu_wr = (which == 2);
      hst_rd = (which == 3);
      fifo_last_in  = last && (i == n - 1);
      fifo_last_out = last && (i == n - 1);
      tick();
    end
    hst_wr = 0; cpu_rd = 0; cpu_wr = 0; hst_rd = 0;
    fifo_last_in = 0; fifo_last_out = 0;
  endtask

  task automatic start_cmd(input bit wr, input logic [7:0] cnt);
    cmd_start = 1; cmd_write = wr; sector_count = cnt;
    tick();
    cmd_start = 0; cmd_write = 0; sector_count = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    clk7_en = 1; reset_n = 0;
    push_exp("reset_state", 5'b00000, 9'd0);
    tick(); tick();
    e = sb.pop_front(); checks++;
    if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
      errors++;
      $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_read();
    string steps[6] = '{"rd_accept", "rd_clr_drop", "rd_sec1_full", "rd_sec1_drained", "rd_sec2_full", "rd_done"};
    logic [4:0] fl[6] = '{5'b10011, 5'b10010, 5'b01100, 5'b10110, 5'b01100, 5'b00100};
    logic [8:0] sl[6] = '{9'd2, 9'd2, 9'd2, 9'd1, 9'd1, 9'd0};
    for (int k = 0; k < 6; k++) begin
      push_exp(steps[k], fl[k], sl[k]);
      case (k)
        0: start_cmd(1'b0, 8'd2);
        1: tick();
        2, 4: burst(0, 256, 1'b1);
        default: burst(1, 256, 1'b1);
      endcase
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
      if (k == 1) begin
        cpu_wr = 1; #1;
        checks++;
        if (fifo_wr !== 1'b0 || fifo_host !== 1'b1) begin
          errors++;
          $display("[TB] FAIL cpu_wr_in_rd_host: got fifo_wr=%b fifo_host=%b, expected 0 1", fifo_wr, fifo_host);
        end
        cpu_wr = 0; hst_wr = 1; #1;
        checks++;
        if (fifo_wr !== 1'b1 || fifo_rd !== 1'b0) begin
          errors++;
          $display("[TB] FAIL hst_wr_in_rd_host: got fifo_wr=%b fifo_rd=%b, expected 1 0", fifo_wr, fifo_rd);
        end
        hst_wr = 0;
      end
    end
    push_exp("rd_status_clear", 5'b00000, 9'd0);
    status_rd = 1; tick(); status_rd = 0;
    e = sb.pop_front(); checks++;
    if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
      errors++;
      $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
    end
  endtask

  task automatic test_write();
    push_exp("wr_accept", 5'b11001, 9'd1);
    push_exp("wr_to_host", 5'b10010, 9'd1);
    push_exp("wr_done_status_race", 5'b00100, 9'd0);
    push_exp("wr_status_clear", 5'b00000, 9'd0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: start_cmd(1'b1, 8'd1);
        1: burst(2, 256, 1'b1);
        2: begin
          burst(3, 255, 1'b0);
          hst_rd = 1; fifo_last_out = 1; status_rd = 1;
          #1;
          checks++;
          if (fifo_rd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hst_rd_in_wr_host: got fifo_rd=%b, expected 1", fifo_rd);
          end
          tick();
          hst_rd = 0; fifo_last_out = 0; status_rd = 0;
        end
        default: begin
          status_rd = 1; tick(); status_rd = 0;
        end
      endcase
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
      if (k == 0) begin
        checks++;
        if (fifo_host !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fifo_host_wr_cpu: got %b, expected 0", fifo_host);
        end
      end
    end
  endtask

  task automatic test_count_zero_abort();
    push_exp("cnt0_accept", 5'b10011, 9'd256);
    push_exp("abort_reach_rd_cpu", 5'b01100, 9'd256);
    push_exp("abort_mid_sector", 5'b00101, 9'd0);
    push_exp("abort_clr_once", 5'b00100, 9'd0);
    push_exp("after_abort_accept", 5'b11001, 9'd3);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: start_cmd(1'b0, 8'd0);
        1: burst(0, 256, 1'b1);
        2: begin
          burst(1, 100, 1'b0);
          abort = 1; tick(); abort = 0;
        end
        3: tick();
        default: start_cmd(1'b1, 8'd3);
      endcase
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
    end
  endtask

  task automatic test_ignore_and_enable();
    push_exp("cmd_ignored_busy", 5'b01000, 9'd3);
    push_exp("clk7_en_low_hold", 5'b01000, 9'd3);
    push_exp("clk7_en_high_move", 5'b10010, 9'd3);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: start_cmd(1'b0, 8'd5);
        1: begin
          clk7_en = 0; cpu_wr = 1; fifo_last_in = 1;
          repeat (5) tick();
        end
        default: begin
          clk7_en = 1; tick();
          cpu_wr = 0; fifo_last_in = 0;
        end
      endcase
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
    end
  endtask

  task automatic test_abort_vs_start();
    push_exp("abort_in_wr_host", 5'b00001, 9'd0);
    push_exp("abort_beats_start", 5'b00001, 9'd0);
    for (int k = 0; k < 2; k++) begin
      abort = 1;
      cmd_start = (k == 1); sector_count = 8'd9;
      tick();
      abort = 0; cmd_start = 0; sector_count = 0;
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    push_exp("mid_accept", 5'b10011, 9'd7);
    push_exp("async_reset", 5'b00000, 9'd0);
    push_exp("post_reset_accept", 5'b10011, 9'd4);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: start_cmd(1'b0, 8'd7);
        1: begin
          #2; clk7_en = 0; reset_n = 0; #1;
        end
        default: begin
          @(negedge clk);
          reset_n = 1; clk7_en = 1;
          start_cmd(1'b0, 8'd4);
        end
      endcase
      e = sb.pop_front(); checks++;
      if ({obs_flags, sectors_left} !== {e.flags, e.sl}) begin
        errors++;
        $display("[TB] FAIL %s: got flags=%b sl=%0d, expected flags=%b sl=%0d", e.name, obs_flags, sectors_left, e.flags, e.sl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_count_zero_abort();
    test_ignore_and_enable();
    test_abort_vs_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
